// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter: widths, starvation limit
// and the response-owner encoding.
package mem_arbiter_pkg;

  localparam int MEM_FULLW      = 32;
  localparam int MEM_STARVE_MAX = 3;

  typedef enum logic [1:0] {
    MEM_OWN_NONE = 2'd0,
    MEM_OWN_IF   = 2'd1,
    MEM_OWN_LS   = 2'd2
  } mem_owner_e;

  // Owner of next cycle's read data, derived from this cycle's grants.
  function automatic mem_owner_e owner_of(input logic if_gnt, input logic ls_gnt);
    mem_owner_e own;
    own = MEM_OWN_NONE;
    if (ls_gnt)      own = MEM_OWN_LS;
    else if (if_gnt) own = MEM_OWN_IF;
    return own;
  endfunction

endpackage

// File: rtl/mem_arbiter_sat_counter.sv
// Saturating run-length counter: counts up while inc_i is high, clears otherwise.
module mem_arbiter_sat_counter #(
  parameter int WIDTH = 2,
  parameter int MAX   = 3
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = '0;
    if (inc_i) begin
      count_d = (count_q == WIDTH'(MAX)) ? count_q : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous-read RAM.
// Load/store normally wins; fetch is forced after STARVE_MAX consecutive losses.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WIDTH      = MEM_FULLW,
  parameter int STARVE_MAX = MEM_STARVE_MAX
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic             if_gnt,
  output logic             if_valid,
  output logic [WIDTH-1:0] if_rdata,
  input  logic             ls_req,
  input  logic             ls_we,
  input  logic             ls_lock,
  input  logic [WIDTH-1:0] ls_addr,
  input  logic [WIDTH-1:0] ls_wdata,
  output logic             ls_gnt,
  output logic             ls_valid,
  output logic [WIDTH-1:0] ls_rdata,
  output logic [WIDTH-1:0] mem_ad,
  output logic [WIDTH-1:0] mem_d,
  output logic             mem_we,
  input  logic [WIDTH-1:0] mem_q
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0]    streak;
  logic             fetch_force;
  logic             ls_gnt_d;
  logic             if_gnt_d;
  logic [WIDTH-1:0] ad_q;
  logic [WIDTH-1:0] ad_d;
  mem_owner_e       owner_q;
  mem_owner_e       owner_d;

  // Grants are gated by nreset so nothing reaches the RAM while held in reset.
  assign fetch_force = if_req && !ls_lock && (streak == CW'(STARVE_MAX));
  assign ls_gnt_d    = nreset && ls_req && !fetch_force;
  assign if_gnt_d    = nreset && if_req && !ls_gnt_d && !ls_lock;

  always_comb begin
    ad_d = ad_q;
    if (ls_gnt_d)      ad_d = ls_addr;
    else if (if_gnt_d) ad_d = if_addr;
  end

  assign owner_d = owner_of(if_gnt_d, ls_gnt_d);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ad_q    <= '0;
      owner_q <= MEM_OWN_NONE;
    end else begin
      ad_q    <= ad_d;
      owner_q <= owner_d;
    end
  end

  mem_arbiter_sat_counter #(
    .WIDTH (CW),
    .MAX   (STARVE_MAX)
  ) u_streak (
    .clk     (clk),
    .nreset  (nreset),
    .inc_i   (ls_gnt_d && if_req),
    .count_o (streak)
  );

  assign ls_gnt   = ls_gnt_d;
  assign if_gnt   = if_gnt_d;
  assign mem_ad   = ad_d;
  assign mem_we   = ls_gnt_d && ls_we;
  assign mem_d    = nreset ? ls_wdata : '0;

  assign if_valid = (owner_q == MEM_OWN_IF);
  assign ls_valid = (owner_q == MEM_OWN_LS);
  assign if_rdata = mem_q;
  assign ls_rdata = mem_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: reference arbitration model, behavioural RAM,
// directed scenarios followed by constrained-random traffic.
module tb_mem_arbiter;

  localparam int W    = 32;
  localparam int SMAX = 3;

  logic         clk = 1'b0;
  logic         nreset;
  logic         if_req, ls_req, ls_we, ls_lock;
  logic [W-1:0] if_addr, ls_addr, ls_wdata;
  logic         if_gnt, if_valid, ls_gnt, ls_valid, mem_we;
  logic [W-1:0] if_rdata, ls_rdata, mem_ad, mem_d, mem_q;

  always #5 clk = ~clk;

  mem_arbiter #(.WIDTH(W), .STARVE_MAX(SMAX)) dut (
    .clk      (clk),
    .nreset   (nreset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_valid (if_valid),
    .if_rdata (if_rdata),
    .ls_req   (ls_req),
    .ls_we    (ls_we),
    .ls_lock  (ls_lock),
    .ls_addr  (ls_addr),
    .ls_wdata (ls_wdata),
    .ls_gnt   (ls_gnt),
    .ls_valid (ls_valid),
    .ls_rdata (ls_rdata),
    .mem_ad   (mem_ad),
    .mem_d    (mem_d),
    .mem_we   (mem_we),
    .mem_q    (mem_q)
  );

  function automatic logic [W-1:0] init_word(input int i);
    return 32'hA5A50000 ^ (32'(i) * 32'h00010003);
  endfunction

  // Behavioural RAM: 1-cycle registered read, reloaded with known contents in reset.
  logic [W-1:0] ram [0:255];
  always @(posedge clk) begin
    if (!nreset) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
      mem_q <= '0;
    end else begin
      mem_q <= ram[mem_ad[9:2]];
      if (mem_we) ram[mem_ad[9:2]] <= mem_d;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int           due;
    bit           chk;
    logic [W-1:0] data;
  } sb_t;

  sb_t          if_sb[$];
  sb_t          ls_sb[$];
  logic [W-1:0] model_mem [0:255];
  int           run;
  logic [W-1:0] last_ad;
  bit           got_if, got_ls;
  bit           mon_en = 1'b0;
  int           tests = 0;
  int           fails = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) model_mem[i] = init_word(i);
    if_sb.delete();
    ls_sb.delete();
    run     = 0;
    last_ad = '0;
    got_if  = 1'b0;
    got_ls  = 1'b0;
  endtask

  // One arbitration cycle: drive, predict from the grant rules, check, record responses.
  task automatic cycle(input bit ifr, input logic [W-1:0] ifa, input bit lsr, input bit lsw,
                       input bit lsl, input logic [W-1:0] lsa, input logic [W-1:0] lsd);
    bit           turn, e_ls, e_if;
    logic [W-1:0] e_ad;
    @(negedge clk);
    if_req = ifr; if_addr = ifa; ls_req = lsr; ls_we = lsw;
    ls_lock = lsl; ls_addr = lsa; ls_wdata = lsd;
    #1;
    turn = ifr && !lsl && (run >= SMAX);
    e_ls = lsr && !turn;
    e_if = ifr && !lsl && !e_ls;
    e_ad = e_ls ? lsa : (e_if ? ifa : last_ad);
    check("ls_gnt", 32'(ls_gnt), 32'(e_ls));
    check("if_gnt", 32'(if_gnt), 32'(e_if));
    check("mem_we", 32'(mem_we), 32'(e_ls && lsw));
    check("mem_ad", mem_ad, e_ad);
    if (e_ls && lsw) check("mem_d", mem_d, lsd);
    if (e_if) if_sb.push_back('{due: cyc + 1, chk: 1'b1, data: model_mem[ifa[9:2]]});
    if (e_ls) begin
      if (lsw) begin
        ls_sb.push_back('{due: cyc + 1, chk: 1'b0, data: '0});
        model_mem[lsa[9:2]] = lsd;
      end else begin
        ls_sb.push_back('{due: cyc + 1, chk: 1'b1, data: model_mem[lsa[9:2]]});
      end
    end
    run     = (e_ls && ifr) ? ((run < SMAX) ? run + 1 : SMAX) : 0;
    last_ad = e_ad;
    got_if  = e_if;
    got_ls  = e_ls;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, '0, 0, 0, 0, '0, '0);
  endtask

  // Monitor: pops the scoreboard whenever a response is due and checks the DUT output.
  task automatic monitor();
    bit  exp_v;
    sb_t e;
    forever begin
      @(negedge clk);
      if (mon_en && nreset) begin
        exp_v = (if_sb.size() > 0) && (if_sb[0].due == cyc);
        check("if_valid", 32'(if_valid), 32'(exp_v));
        if (exp_v) begin
          e = if_sb.pop_front();
          if (e.chk) check("if_rdata", if_rdata, e.data);
        end
        exp_v = (ls_sb.size() > 0) && (ls_sb[0].due == cyc);
        check("ls_valid", 32'(ls_valid), 32'(exp_v));
        if (exp_v) begin
          e = ls_sb.pop_front();
          if (e.chk) check("ls_rdata", ls_rdata, e.data);
        end
      end
    end
  endtask

  initial begin
    logic [7:0]   pat;
    bit           c_ifr, c_lsr, c_lsw, c_lock;
    logic [W-1:0] c_ifa, c_lsa, c_lsd;
    int           lock_cnt;

    model_reset();
    fork
      monitor();
    join_none

    // Reset with both requesters active: everything must stay quiet.
    nreset = 1'b0;
    if_req = 1'b1; if_addr = 32'h24; ls_req = 1'b1; ls_we = 1'b1; ls_lock = 1'b0;
    ls_addr = 32'h28; ls_wdata = 32'h12345678;
    #12;
    check("rst_if_gnt", 32'(if_gnt), 32'd0);
    check("rst_ls_gnt", 32'(ls_gnt), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_ls_valid", 32'(ls_valid), 32'd0);
    check("rst_mem_ad", mem_ad, 32'd0);
    check("rst_mem_d", mem_d, 32'd0);
    @(negedge clk);
    if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    nreset = 1'b1;
    mon_en = 1'b1;
    #1;
    check("post_rst_if_valid", 32'(if_valid), 32'd0);
    check("post_rst_ls_valid", 32'(ls_valid), 32'd0);
    check("post_rst_mem_ad", mem_ad, 32'd0);

    // Fetch-only stream.
    cycle(1, 32'h0, 0, 0, 0, '0, '0);
    cycle(1, 32'h4, 0, 0, 0, '0, '0);
    cycle(1, 32'h8, 0, 0, 0, '0, '0);
    idle(2);

    // Store then load to the same address on consecutive cycles.
    cycle(0, '0, 1, 1, 0, 32'h10, 32'hDEADBEEF);
    cycle(0, '0, 1, 0, 0, 32'h10, '0);
    idle(2);

    // Contention with no lock: expect LS,LS,LS,IF repeating.
    pat = '0;
    for (int i = 0; i < 8; i++) begin
      cycle(1, 32'h40, 1, 0, 0, 32'h44, '0);
      pat = {pat[6:0], ls_gnt};
    end
    check("contention_pattern", 32'(pat), 32'(8'b1110_1110));
    idle(2);

    // Locked atomic sequence: fetch must never win, even past the starvation limit.
    for (int i = 0; i < 6; i++) cycle(1, 32'h48, (i % 2) == 0, 0, 1, 32'h4C, '0);
    cycle(1, 32'h48, 0, 0, 0, '0, '0);
    idle(2);

    // Asynchronous reset while a fetch response is in flight.
    cycle(1, 32'h50, 0, 0, 0, '0, '0);
    @(posedge clk);
    #2;
    nreset = 1'b0;
    #1;
    check("midrst_if_valid", 32'(if_valid), 32'd0);
    check("midrst_if_gnt", 32'(if_gnt), 32'd0);
    check("midrst_ls_gnt", 32'(ls_gnt), 32'd0);
    check("midrst_mem_we", 32'(mem_we), 32'd0);
    model_reset();
    @(posedge clk);
    #2;
    nreset = 1'b1;
    cycle(1, 32'h50, 0, 0, 0, '0, '0);
    idle(2);

    // Random traffic honouring the hold-until-granted rule.
    c_ifr = 1'b0; c_lsr = 1'b0; c_lsw = 1'b0; c_lock = 1'b0;
    c_ifa = '0; c_lsa = '0; c_lsd = '0; lock_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      if (!c_ifr || got_if) begin
        c_ifr = ($urandom % 4) != 0;
        c_ifa = 32'($urandom_range(0, 31)) << 2;
      end
      if (!c_lsr || got_ls) begin
        c_lsr = ($urandom % 3) != 0;
        c_lsw = ($urandom % 2) != 0;
        c_lsa = 32'($urandom_range(0, 31)) << 2;
        c_lsd = $urandom;
      end
      if (lock_cnt > 0) lock_cnt--;
      else if (($urandom % 16) == 0) lock_cnt = $urandom_range(1, 4);
      c_lock = lock_cnt > 0;
      cycle(c_ifr, c_ifa, c_lsr, c_lsw, c_lock, c_lsa, c_lsd);
    end
    idle(3);
    check("if_sb_drained", 32'(if_sb.size()), 32'd0);
    check("ls_sb_drained", 32'(ls_sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
